// File: rtl/bram_readback_serializer.sv
// Sweeps a range of BRAM addresses, captures each wide read word and streams it
// out one DWIDTH-bit element at a time over valid/ready, with a running 16-bit checksum.
module bram_readback_serializer #(
  parameter int DWIDTH             = 8,
  parameter int DESIGN_SIZE        = 32,
  parameter int AWIDTH             = 10,
  parameter int MEM_ACCESS_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [AWIDTH-1:0]             base_addr,
  input  logic [AWIDTH:0]               num_words,
  output logic [AWIDTH-1:0]             bram_addr,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] bram_rdata,
  output logic [DWIDTH-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   checksum
);

  localparam int WW = DESIGN_SIZE * DWIDTH;
  localparam int BW = (DESIGN_SIZE > 1) ? $clog2(DESIGN_SIZE) : 1;
  localparam int LW = (MEM_ACCESS_LATENCY > 1) ? $clog2(MEM_ACCESS_LATENCY) : 1;
  localparam logic [AWIDTH:0] WORD_ONE  = (AWIDTH+1)'(1);
  localparam logic [BW-1:0]   BYTE_LAST = BW'(DESIGN_SIZE - 1);
  localparam logic [LW-1:0]   LAT_LAST  = LW'(MEM_ACCESS_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CAPTURE,
    S_SEND,
    S_FIN
  } state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] base_q;
  logic [AWIDTH:0]   num_q;
  logic [AWIDTH:0]   word_idx;
  logic [BW-1:0]     byte_idx;
  logic [LW-1:0]     lat_cnt;
  logic [WW-1:0]     word_q;
  logic [DWIDTH-1:0] word_bytes [DESIGN_SIZE];

  logic accept;
  logic beat;
  logic last_byte;
  logic last_word;
  logic lat_done;

  always_comb begin
    for (int unsigned i = 0; i < DESIGN_SIZE; i++) begin
      word_bytes[i] = word_q[i*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    accept    = 1'b0;
    beat      = 1'b0;
    last_byte = (byte_idx == BYTE_LAST);
    last_word = ((word_idx + WORD_ONE) == num_q);
    lat_done  = (lat_cnt == LAT_LAST);
    state_nxt = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_data  = word_bytes[byte_idx];

    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            accept    = 1'b1;
            state_nxt = S_ADDR;
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_ADDR: begin
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (lat_done) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy      = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = last_byte && last_word;
        beat      = out_ready;
        if (out_ready && last_byte) state_nxt = last_word ? S_FIN : S_ADDR;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      lat_cnt   <= '0;
      word_q    <= '0;
      bram_addr <= '0;
      checksum  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base_q   <= base_addr;
        num_q    <= num_words;
        word_idx <= '0;
        checksum <= '0;
      end
      case (state)
        S_ADDR: begin
          // Address arithmetic is modulo 2^AWIDTH so a sweep past the top wraps to 0.
          bram_addr <= base_q + word_idx[AWIDTH-1:0];
          lat_cnt   <= '0;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt + LW'(1);
        end
        S_CAPTURE: begin
          word_q   <= bram_rdata;
          byte_idx <= '0;
        end
        S_SEND: begin
          if (beat) begin
            checksum <= checksum + 16'(out_data);
            byte_idx <= byte_idx + BW'(1);
            if (last_byte) word_idx <= word_idx + WORD_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_readback_serializer.sv
// Scoreboard bench: a reference model queues expected bytes per sweep, a monitor
// pops and compares on every accepted beat.
module tb_bram_readback_serializer;

  localparam int DW = 8;
  localparam int DS = 32;
  localparam int AW = 10;
  localparam int WW = DS * DW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic [AW-1:0] bram_addr;
  logic [WW-1:0] bram_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [15:0]   checksum;

  bram_readback_serializer #(
    .DWIDTH(DW),
    .DESIGN_SIZE(DS),
    .AWIDTH(AW),
    .MEM_ACCESS_LATENCY(1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .base_addr(base_addr),
    .num_words(num_words),
    .bram_addr(bram_addr),
    .bram_rdata(bram_rdata),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [0:1023];
  always @(posedge clk) bram_rdata <= mem[bram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [AW-1:0] a;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  logic [15:0] model_ck = '0;
  int   rmode = 0;
  bit   mon_en = 1'b0;
  int   beats = 0;
  int   first_valid_cyc = -1;
  int   last_beat_cyc = -1;
  bit   any_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Consumer ready generator
  initial begin
    bit pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          if (out_valid && !pv) out_ready = 1'b1;
          else out_ready = ~out_ready;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      pv = out_valid;
    end
  end

  // Monitor
  initial begin
    bit stall_prev = 1'b0;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_prev = 1'b0;
      end else begin
        if (busy) any_busy = 1'b1;
        if (stall_prev) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, pd);
          check("stall_last", out_last, pl);
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid) check("busy_while_valid", busy, 1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e.d);
            check("beat_last", out_last, e.l);
            check("beat_addr", bram_addr, e.a);
          end
          beats++;
          last_beat_cyc = cyc;
        end
        stall_prev = out_valid && !out_ready;
        pd = out_data;
        pl = out_last;
      end
    end
  end

  // Reference model: bytes of words base..base+n-1 (mod 1024), low byte first.
  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n, output int c0);
    logic [WW-1:0] w;
    exp_t e;
    if (n != 0) model_ck = '0;
    for (int wi = 0; wi < int'(n); wi++) begin
      e.a = AW'((int'(b) + wi) % 1024);
      w = mem[e.a];
      for (int k = 0; k < DS; k++) begin
        e.d = w[k*DW +: DW];
        e.l = (wi == int'(n) - 1) && (k == DS - 1);
        model_ck = model_ck + 16'(e.d);
        exp_q.push_back(e);
      end
    end
    first_valid_cyc = -1;
    beats = 0;
    any_busy = 1'b0;
    @(posedge clk);
    #1;
    base_addr = b;
    num_words = n;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    num_words = (AW+1)'($urandom);
  endtask

  task automatic wait_done(input logic [AW:0] n, input int c0, input int poke, input bit fin_poke);
    int t = 0;
    int limit = int'(n) * (DS * 4 + 10) + 40;
    do begin
      @(negedge clk);
      t++;
      if (poke > 0 && t == poke) begin
        start = 1'b1;
        num_words = 11'd9;
        base_addr = 10'd200;
        @(negedge clk);
        t++;
        start = 1'b0;
      end
    end while (!done && t < limit);
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    check("valid_at_done", out_valid, 0);
    if (n != 0) begin
      check("done_after_last", cyc, last_beat_cyc + 1);
      check("first_valid_latency", first_valid_cyc, c0 + 4);
    end else begin
      check("done_after_start", cyc, c0 + 1);
      check("no_beats", beats, 0);
      check("busy_never", any_busy, 0);
    end
    check("queue_drained", exp_q.size(), 0);
    check("checksum", checksum, model_ck);
    if (fin_poke) begin
      start = 1'b1;
      num_words = 11'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    if (fin_poke) begin
      any_busy = 1'b0;
      repeat (8) @(negedge clk);
      check("fin_start_ignored", any_busy, 0);
      check("checksum_hold", checksum, model_ck);
    end
  endtask

  task automatic run_sweep(input logic [AW-1:0] b, input logic [AW:0] n, input int poke, input bit fin_poke);
    int c0;
    launch(b, n, c0);
    wait_done(n, c0, poke, fin_poke);
  endtask

  initial begin
    int c0;
    int t;
    bit saw_done;
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < WW / 32; k++) mem[i][k*32 +: 32] = $urandom;
    end
    for (int k = 0; k < DS; k++) mem[5][k*DW +: DW] = DW'(k);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;

    // T1: incrementing bytes, full ready
    rmode = 0;
    run_sweep(10'd5, 11'd1, 0, 1'b0);
    check("t1_checksum_const", checksum, 16'h01F0);

    // T2: alternating ready
    rmode = 1;
    run_sweep(10'd5, 11'd1, 0, 1'b0);
    check("t2_span", last_beat_cyc - first_valid_cyc + 1, 63);
    check("t2_beats", beats, 32);

    // T3: address wrap
    rmode = 0;
    run_sweep(10'd1023, 11'd2, 0, 1'b0);
    check("t3_beats", beats, 64);

    // T4: zero-length sweep
    run_sweep(10'd7, 11'd0, 0, 1'b0);
    check("t4_checksum_hold", checksum, model_ck);

    // T5: start mid-sweep and during FIN is ignored
    rmode = 2;
    run_sweep(10'd40, 11'd3, 20, 1'b1);
    check("t5_beats", beats, 96);

    // T6: reset during word 1 of 3
    rmode = 0;
    launch(10'd300, 11'd3, c0);
    t = 0;
    while (beats < DS + 5 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("t6_reach_word1", beats >= DS + 5, 1);
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("t6_bram_addr", bram_addr, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_data", out_data, 0);
    check("t6_out_last", out_last, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_checksum", checksum, 0);
    exp_q.delete();
    model_ck = '0;
    saw_done = 1'b0;
    mon_en = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || out_valid) saw_done = 1'b1;
    end
    check("t6_abandoned", saw_done, 0);
    run_sweep(10'd300, 11'd3, 0, 1'b0);

    // Randomized sweeps with random back-pressure
    rmode = 2;
    for (int r = 0; r < 6; r++) begin
      run_sweep(AW'($urandom), (AW+1)'($urandom_range(1, 4)), 0, 1'b0);
    end

    // Full address space, wrapping through 0
    rmode = 0;
    run_sweep(10'd700, 11'd1024, 0, 1'b0);
    check("full_beats", beats, 1024 * DS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
